// File: rtl/fazyrv_stb.sv
// fazyrv_stb -- serial store data path.
//
// Collects the serially streamed rs2 value (CHUNKSIZE bits per cycle, LSB
// chunk first) into a 32-bit word. It then replicates and aligns the word
// for SB/SH/SW, generates the byte selects and runs one Wishbone-classic
// write. done_o releases the core's store sequence.
//
// Parameters:
//   CHUNKSIZE   bits per serial cycle (1, 2, 4, 8, 16, 32)
//   NO_ICYC     chunks per word, derived from CHUNKSIZE
//
// Ports:
//   clk_i, rst_i               clock, async active-high reset
//   start_i                    store request, sampled in IDLE only
//   ls_b_i/ls_h_i/ls_w_i       access size, sampled with start_i
//   adr_lsbs_i                 address bits [1:0], sampled with start_i
//   ser_vld_i, ser_i           serial rs2 chunk stream
//   wbm_cyc_o/stb_o/we_o       Wishbone write cycle
//   wbm_sel_o, wbm_dat_o       byte selects / write data (zero outside REQ)
//   wbm_ack_i                  bus acknowledge
//   busy_o                     sequence in progress
//   done_o                     one-cycle completion pulse
//   misalngd_o                 misaligned-store pulse with done_o
//
// Build option:
//   FAZYRV_STB_MISALGN_EN  misaligned half/word stores trap (no bus cycle).
//                          Without it, the low address bits are forced
//                          aligned and the write is issued.

module fazyrv_stb #(
    parameter int CHUNKSIZE = 8,
    parameter int NO_ICYC   = 32 / CHUNKSIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 ls_b_i,
    input  logic                 ls_h_i,
    input  logic                 ls_w_i,
    input  logic [1:0]           adr_lsbs_i,
    input  logic                 ser_vld_i,
    input  logic [CHUNKSIZE-1:0] ser_i,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic                 wbm_we_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_dat_o,
    input  logic                 wbm_ack_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 misalngd_o
);

    localparam int CW = (NO_ICYC > 1) ? $clog2(NO_ICYC) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, REQ, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t          state;
    size_t           size_q;
    logic [1:0]      adr_q;
    logic [CW-1:0]   cnt;
    logic [31:0]     sreg;
    logic [31:0]     sreg_nxt;
    logic            cyc_q;
    logic [3:0]      sel_q;
    logic [31:0]     dat_q;
    logic            done_q;
    logic            last_chunk;
    logic            trap;
    logic [1:0]      adr_eff;
    logic [3:0]      sel_nxt;
    logic [31:0]     dat_nxt;

    // A full-width chunk replaces the whole register; the slice form
    // below would be empty for CHUNKSIZE=32.
    generate
        if (CHUNKSIZE == 32) begin : g_full
            assign sreg_nxt = ser_i;
        end else begin : g_shift
            assign sreg_nxt = {ser_i, sreg[31:CHUNKSIZE]};
        end
    endgenerate

    assign last_chunk = ser_vld_i && (cnt == CW'(NO_ICYC - 1));

    // Alignment: half uses adr[1] only, word always lane 0. With the trap
    // option, the raw address decides whether the store is misaligned.
    always_comb begin
        adr_eff = adr_q;
        trap    = 1'b0;
        case (size_q)
            SZ_H: begin
                adr_eff = {adr_q[1], 1'b0};
`ifdef FAZYRV_STB_MISALGN_EN
                trap    = adr_q[0];
`endif
            end
            SZ_W: begin
                adr_eff = 2'b00;
`ifdef FAZYRV_STB_MISALGN_EN
                trap    = |adr_q;
`endif
            end
            default: ;
        endcase
    end

    // Data is built from sreg_nxt so the last chunk lands in the same
    // cycle the bus request is raised.
    always_comb begin
        sel_nxt = 4'b1111;
        dat_nxt = sreg_nxt;
        case (size_q)
            SZ_B: begin
                sel_nxt = 4'b0001 << adr_eff;
                dat_nxt = {4{sreg_nxt[7:0]}};
            end
            SZ_H: begin
                sel_nxt = 4'b0011 << adr_eff;
                dat_nxt = {2{sreg_nxt[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef FAZYRV_STB_MISALGN_EN
    logic misalngd_q;
    assign misalngd_o = misalngd_q;
`else
    assign misalngd_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            size_q <= SZ_W;
            adr_q  <= 2'b00;
            cnt    <= '0;
            sreg   <= '0;
            cyc_q  <= 1'b0;
            sel_q  <= 4'b0000;
            dat_q  <= '0;
            done_q <= 1'b0;
`ifdef FAZYRV_STB_MISALGN_EN
            misalngd_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef FAZYRV_STB_MISALGN_EN
            misalngd_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_i) begin
                        // Priority b > h > w; nothing set also means word.
                        if (ls_b_i)      size_q <= SZ_B;
                        else if (ls_h_i) size_q <= SZ_H;
                        else if (ls_w_i) size_q <= SZ_W;
                        else             size_q <= SZ_W;
                        adr_q <= adr_lsbs_i;
                        cnt   <= '0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (ser_vld_i) begin
                        sreg <= sreg_nxt;
                        cnt  <= last_chunk ? '0 : cnt + CW'(1);
                        if (last_chunk) begin
                            if (trap) begin
                                state  <= DONE;
                                done_q <= 1'b1;
`ifdef FAZYRV_STB_MISALGN_EN
                                misalngd_q <= 1'b1;
`endif
                            end else begin
                                state <= REQ;
                                cyc_q <= 1'b1;
                                sel_q <= sel_nxt;
                                dat_q <= dat_nxt;
                            end
                        end
                    end
                end
                REQ: begin
                    if (wbm_ack_i) begin
                        cyc_q  <= 1'b0;
                        sel_q  <= 4'b0000;
                        dat_q  <= '0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;  // DONE
            endcase
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_sel_o = sel_q;
    assign wbm_dat_o = dat_q;
    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;

endmodule

// File: tb/tb_fazyrv_stb.sv
// Directed bench for fazyrv_stb: one CHUNKSIZE=8 instance for the bulk of
// the scenarios and one CHUNKSIZE=1 instance for the bit-serial case.
module tb_fazyrv_stb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, ls_b, ls_h, ls_w, ser_vld, ack;
    logic [1:0]  adr;
    logic [7:0]  ser;
    logic        cyc, stb, we, busy, done, mis;
    logic [3:0]  sel;
    logic [31:0] dat;

    logic        s1_start, s1_w, s1_zero, s1_vld, s1_ack;
    logic [1:0]  s1_adr;
    logic [0:0]  s1_ser;
    logic        s1_cyc, s1_stb, s1_we, s1_busy, s1_done, s1_mis;
    logic [3:0]  s1_sel;
    logic [31:0] s1_dat;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    logic cyc_prev = 1'b0;

    always #5 clk = ~clk;

    fazyrv_stb #(.CHUNKSIZE(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .ls_b_i(ls_b), .ls_h_i(ls_h), .ls_w_i(ls_w), .adr_lsbs_i(adr),
        .ser_vld_i(ser_vld), .ser_i(ser),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_dat_o(dat), .wbm_ack_i(ack),
        .busy_o(busy), .done_o(done), .misalngd_o(mis)
    );

    fazyrv_stb #(.CHUNKSIZE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(s1_start),
        .ls_b_i(s1_zero), .ls_h_i(s1_zero), .ls_w_i(s1_w), .adr_lsbs_i(s1_adr),
        .ser_vld_i(s1_vld), .ser_i(s1_ser),
        .wbm_cyc_o(s1_cyc), .wbm_stb_o(s1_stb), .wbm_we_o(s1_we), .wbm_sel_o(s1_sel),
        .wbm_dat_o(s1_dat), .wbm_ack_i(s1_ack),
        .busy_o(s1_busy), .done_o(s1_done), .misalngd_o(s1_mis)
    );

    // Counts done pulses and bus-cycle starts of the 8-bit instance.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (cyc === 1'b1 && cyc_prev !== 1'b1) wr_cnt <= wr_cnt + 1;
        cyc_prev <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One store on the 8-bit instance. pat/plen give the ser_vld_i pattern
    // (LSB first, all ones once exhausted); repulse drives start_i in gaps.
    task automatic store(input string tag, input logic [2:0] bhw, input logic [1:0] a,
                         input logic [31:0] word, input logic [15:0] pat, input int plen,
                         input bit repulse, input int ackdly, input bit trap,
                         input logic [31:0] edat, input logic [3:0] esel);
        int  bd, bw, sent, i;
        bit  v;
        bd = done_cnt;
        bw = wr_cnt;
        @(negedge clk);
        start = 1'b1; {ls_b, ls_h, ls_w} = bhw; adr = a;
        @(negedge clk);
        start = 1'b0; {ls_b, ls_h, ls_w} = 3'b000; adr = 2'b00;
        chk({tag, ".busy"}, busy, 1);
        sent = 0;
        i = 0;
        while (sent < 4) begin
            v = (i < plen) ? pat[i] : 1'b1;
            ser_vld = v;
            ser = v ? word[8*sent +: 8] : 8'h00;
            start = repulse && !v;
            @(negedge clk);
            if (v) sent++;
            i++;
        end
        ser_vld = 1'b0; ser = 8'h00; start = 1'b0;
        if (trap) begin
            chk({tag, ".cyc"}, cyc, 0);
            chk({tag, ".done"}, done, 1);
            chk({tag, ".mis"}, mis, 1);
            @(negedge clk);
            chk({tag, ".done_end"}, done, 0);
            chk({tag, ".mis_end"}, mis, 0);
        end else begin
            for (int k = 0; k <= ackdly; k++) begin
                chk({tag, ".cyc"}, cyc, 1);
                chk({tag, ".stbwe"}, {stb, we}, 2'b11);
                chk({tag, ".dat"}, dat, edat);
                chk({tag, ".sel"}, sel, esel);
                chk({tag, ".done_early"}, done, 0);
                if (k == ackdly) ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end
            chk({tag, ".cyc_end"}, cyc, 0);
            chk({tag, ".done"}, done, 1);
            chk({tag, ".mis"}, mis, 0);
            chk({tag, ".dat_idle"}, dat, 0);
            chk({tag, ".sel_idle"}, sel, 0);
            @(negedge clk);
            chk({tag, ".done_end"}, done, 0);
        end
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".ndone"}, done_cnt - bd, 1);
        chk({tag, ".nwrite"}, wr_cnt - bw, trap ? 0 : 1);
    endtask

    initial begin
        int bd;
        logic [31:0] w1;
        rst = 1'b1;
        start = 0; ls_b = 0; ls_h = 0; ls_w = 0; adr = 0; ser_vld = 0; ser = 0; ack = 0;
        s1_start = 0; s1_w = 0; s1_zero = 0; s1_vld = 0; s1_ack = 0; s1_adr = 0; s1_ser = 0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.outs", {cyc, stb, we, busy, done, mis}, 0);
        chk("reset.sel", sel, 0);
        chk("reset.dat", dat, 0);
        rst = 1'b0;

        // Serial data in IDLE is ignored.
        ser_vld = 1'b1; ser = 8'hFF;
        @(negedge clk);
        ser_vld = 1'b0; ser = 8'h00;
        chk("idle_ser.busy", busy, 0);

        store("sw", 3'b001, 2'd0, 32'h12345678, 16'h0, 0, 1'b0, 2, 1'b0, 32'h12345678, 4'b1111);
        store("sb3", 3'b100, 2'd3, 32'h000000A5, 16'h0, 0, 1'b0, 0, 1'b0, 32'hA5A5A5A5, 4'b1000);
        store("sh2", 3'b010, 2'd2, 32'h0000BEEF, 16'h0, 0, 1'b0, 1, 1'b0, 32'hBEEFBEEF, 4'b1100);
        store("sw_gaps", 3'b001, 2'd0, 32'hDEADBEEF, 16'b1011001, 7, 1'b1, 1, 1'b0,
              32'hDEADBEEF, 4'b1111);
        store("prio", 3'b111, 2'd1, 32'h11223344, 16'h0, 0, 1'b0, 0, 1'b0, 32'h44444444, 4'b0010);
        store("nosize", 3'b000, 2'd0, 32'hCAFEF00D, 16'h0, 0, 1'b0, 0, 1'b0, 32'hCAFEF00D, 4'b1111);
`ifdef FAZYRV_STB_MISALGN_EN
        store("sh1", 3'b010, 2'd1, 32'h1234CAFE, 16'h0, 0, 1'b0, 0, 1'b1, 32'h0, 4'b0000);
`else
        store("sh1", 3'b010, 2'd1, 32'h1234CAFE, 16'h0, 0, 1'b0, 0, 1'b0, 32'hCAFECAFE, 4'b0011);
`endif

        // Reset while the bus request is outstanding.
        bd = done_cnt;
        @(negedge clk);
        start = 1'b1; ls_w = 1'b1;
        @(negedge clk);
        start = 1'b0; ls_w = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ser_vld = 1'b1; ser = 8'h10 + 8'(c);
            @(negedge clk);
        end
        ser_vld = 1'b0; ser = 8'h00;
        chk("rst_req.cyc_before", cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req.cycstb", {cyc, stb}, 2'b00);
        chk("rst_req.busy", busy, 0);
        chk("rst_req.dat", dat, 0);
        @(negedge clk);
        chk("rst_req.done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req.ndone", done_cnt - bd, 0);
        store("sw_after_rst", 3'b001, 2'd0, 32'hA1B2C3D4, 16'h0, 0, 1'b0, 1, 1'b0,
              32'hA1B2C3D4, 4'b1111);

        // Bit-serial instance: 32 chunks, ack in the first REQ cycle.
        w1 = 32'h80000001;
        @(negedge clk);
        s1_start = 1'b1; s1_w = 1'b1;
        @(negedge clk);
        s1_start = 1'b0; s1_w = 1'b0;
        for (int b = 0; b < 32; b++) begin
            s1_vld = 1'b1; s1_ser = w1[b];
            @(negedge clk);
        end
        s1_vld = 1'b0; s1_ser = 1'b0;
        chk("cs1.cyc", s1_cyc, 1);
        chk("cs1.dat", s1_dat, 32'h80000001);
        chk("cs1.sel", s1_sel, 4'b1111);
        s1_ack = 1'b1;
        @(negedge clk);
        s1_ack = 1'b0;
        chk("cs1.cyc_end", s1_cyc, 0);
        chk("cs1.done", s1_done, 1);
        @(negedge clk);
        chk("cs1.done_end", s1_done, 0);
        chk("cs1.idle", s1_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
